cv_copy_scheduler: RTL and testbench

// Sequencer/arbiter around the VRAM-to-VRAM copy state machine. Owns source/destination pair cursors,

---
 rtl/cv_copy_scheduler.sv | 216 +++++++++++++++++++++
 tb/tb_cv_copy_scheduler.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cv_copy_scheduler.sv
// Copy sequencer around the VRAM-to-VRAM copy state machine: pair cursors, line-end flags,
// a write-back FIFO and arbitration of the single VRAM command port between reads and writes.
module cv_copy_scheduler #(
  parameter int FIFO_LOG2    = 3,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        nRst,
  input  logic        i_start,
  input  logic [9:0]  i_srcX,
  input  logic [9:0]  i_dstX,
  input  logic [8:0]  i_srcY,
  input  logic [8:0]  i_dstY,
  input  logic [10:0] i_width,
  input  logic [9:0]  i_height,
  output logic        o_active,
  output logic        o_isWidthNot1,
  output logic        o_xb_0,
  output logic        o_wb_0,
  output logic        o_canPush,
  output logic        o_canNearPush,
  output logic        o_endVertical,
  output logic        o_currPairIsLineLast,
  output logic        o_nextPairIsLineLast,
  input  logic        i_read,
  output logic        o_readACK,
  output logic [31:0] o_readData,
  input  logic [2:0]  i_nextX,
  input  logic [2:0]  i_nextY,
  input  logic        i_writeFIFOOut,
  input  logic [31:0] i_wrData,
  input  logic [1:0]  i_wrMask,
  input  logic        i_exitSig,
  output logic        o_memReq,
  output logic        o_memWrite,
  output logic [17:0] o_memAddr,
  output logic [31:0] o_memWData,
  output logic [1:0]  o_memMask,
  input  logic        i_memAck,
  input  logic [31:0] i_memRData,
  output logic        o_done,
  output logic        o_overflow,
  output logic [1:0]  o_dbg_state,
  output logic [8:0]  o_dbg_dst_last
);
  localparam int DEPTH = 1 << FIFO_LOG2;
  localparam int CW = FIFO_LOG2 + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] HI_CNT   = CW'(DEPTH - 2);
  localparam logic [CW-1:0] NEAR_CNT = CW'(DEPTH - 3);
  localparam logic [SW-1:0] STREAK_MAX = SW'(STARVE_LIMIT);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_t;
  state_t state;

  logic [8:0]  src_pair, dst_pair, src_y, dst_y, line;
  logic [8:0]  src_first, dst_first, src_last, dst_last;
  logic [9:0]  height;
  logic        width_not1, xb0, wb0;
  logic        read_pending, in_flight, flight_write;
  logic [17:0] read_addr;
  logic [CW-1:0] count;
  logic [FIFO_LOG2-1:0] rd_ptr, wr_ptr;
  logic [SW-1:0] streak;
  logic [17:0] fifo_addr [DEPTH];
  logic [31:0] fifo_data [DEPTH];
  logic [1:0]  fifo_mask [DEPTH];

  logic        run, busy, fifo_empty, fifo_full, push, pop, accept_rd, rd_req, grant_w, grant_r;
  logic [10:0] src_end, dst_end;

  // End pixel needs 11 bits; bits [9:1] give the last pair already wrapped mod 512.
  assign src_end = 11'(i_srcX) + i_width - 11'd1;
  assign dst_end = 11'(i_dstX) + i_width - 11'd1;

  assign run        = (state == RUN);
  assign busy       = (state != IDLE);
  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == FULL_CNT);
  assign push       = i_writeFIFOOut & ~fifo_full;
  assign pop        = in_flight & flight_write & i_memAck;
  assign accept_rd  = run & i_read & ~read_pending;
  // A fresh i_read competes in the same cycle so back-to-back reads stay contiguous.
  assign rd_req     = run & (read_pending | i_read);
  assign grant_w    = ~in_flight & ~fifo_empty &
                      (~rd_req | (count >= HI_CNT) | (streak >= STREAK_MAX));
  assign grant_r    = ~in_flight & ~grant_w & rd_req;

  assign o_active             = run;
  assign o_isWidthNot1        = busy & width_not1;
  assign o_xb_0               = busy & xb0;
  assign o_wb_0               = busy & wb0;
  assign o_canPush            = busy & (count <= HI_CNT);
  assign o_canNearPush        = busy & (count <= NEAR_CNT);
  assign o_endVertical        = busy & ({1'b0, line} == height - 10'd1);
  assign o_currPairIsLineLast = busy & (src_pair == src_last);
  assign o_nextPairIsLineLast = busy & ((src_pair + 9'd1) == src_last);
  assign o_dbg_state          = state;
  assign o_dbg_dst_last       = dst_last;

  function automatic logic [8:0] step_x(input logic [2:0] code, input logic [8:0] cur,
                                        input logic [8:0] first);
    case (code)
      3'd1:    return cur + 9'd1;
      3'd6:    return first;
      default: return cur;
    endcase
  endfunction

  function automatic logic [8:0] step_y(input logic [2:0] code, input logic [8:0] cur);
    return (code == 3'd4) ? cur + 9'd1 : cur;
  endfunction

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wr_ptr] <= {dst_y, dst_pair};
      fifo_data[wr_ptr] <= i_wrData;
      fifo_mask[wr_ptr] <= i_wrMask;
    end
  end

  always_ff @(posedge clk) begin
    if (!nRst) begin
      state <= IDLE;
      src_pair <= '0; dst_pair <= '0; src_y <= '0; dst_y <= '0; line <= '0;
      src_first <= '0; dst_first <= '0; src_last <= '0; dst_last <= '0;
      height <= '0; width_not1 <= 1'b0; xb0 <= 1'b0; wb0 <= 1'b0;
      read_pending <= 1'b0; read_addr <= '0; in_flight <= 1'b0; flight_write <= 1'b0;
      count <= '0; rd_ptr <= '0; wr_ptr <= '0; streak <= '0;
      o_readACK <= 1'b0; o_readData <= '0; o_memReq <= 1'b0; o_memWrite <= 1'b0;
      o_memAddr <= '0; o_memWData <= '0; o_memMask <= '0; o_done <= 1'b0; o_overflow <= 1'b0;
    end else begin
      o_done    <= 1'b0;
      o_readACK <= 1'b0;
      case (state)
        IDLE: if (i_start) begin
          src_first  <= i_srcX[9:1];
          dst_first  <= i_dstX[9:1];
          src_last   <= src_end[9:1];
          dst_last   <= dst_end[9:1];
          src_pair   <= i_srcX[9:1];
          dst_pair   <= i_dstX[9:1];
          src_y      <= i_srcY;
          dst_y      <= i_dstY;
          line       <= '0;
          height     <= i_height;
          width_not1 <= (i_width != 11'd1);
          xb0        <= i_srcX[0];
          wb0        <= i_width[0];
          state      <= RUN;
        end
        RUN: begin
          src_pair <= step_x(i_nextX, src_pair, src_first);
          src_y    <= step_y(i_nextY, src_y);
          line     <= step_y(i_nextY, line);
          if (i_writeFIFOOut) begin
            dst_pair <= step_x(i_nextX, dst_pair, dst_first);
            dst_y    <= step_y(i_nextY, dst_y);
          end
          if (i_exitSig) state <= DRAIN;
        end
        DRAIN: if (fifo_empty && !in_flight) begin
          state        <= IDLE;
          o_done       <= 1'b1;
          read_pending <= 1'b0;
        end
        default: state <= IDLE;
      endcase

      if (accept_rd) begin
        read_pending <= 1'b1;
        read_addr    <= {src_y, src_pair};
      end

      if (grant_w) begin
        in_flight    <= 1'b1;
        flight_write <= 1'b1;
        o_memReq     <= 1'b1;
        o_memWrite   <= 1'b1;
        o_memAddr    <= fifo_addr[rd_ptr];
        o_memWData   <= fifo_data[rd_ptr];
        o_memMask    <= fifo_mask[rd_ptr];
        streak       <= '0;
      end else if (grant_r) begin
        in_flight    <= 1'b1;
        flight_write <= 1'b0;
        o_memReq     <= 1'b1;
        o_memWrite   <= 1'b0;
        o_memAddr    <= read_pending ? read_addr : {src_y, src_pair};
        o_memWData   <= '0;
        o_memMask    <= '0;
        if (streak < STREAK_MAX) streak <= streak + SW'(1);
      end else if (in_flight && i_memAck) begin
        in_flight  <= 1'b0;
        o_memReq   <= 1'b0;
        o_memWrite <= 1'b0;
        if (!flight_write) begin
          read_pending <= 1'b0;
          o_readData   <= i_memRData;
          o_readACK    <= 1'b1;
        end
      end
      if (fifo_empty) streak <= '0;

      if (push) wr_ptr <= wr_ptr + FIFO_LOG2'(1);
      if (pop)  rd_ptr <= rd_ptr + FIFO_LOG2'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
      if (i_writeFIFOOut && fifo_full) o_overflow <= 1'b1;
    end
  end
endmodule

// File: tb/tb_cv_copy_scheduler.sv
// Bench for cv_copy_scheduler: a randomly-stalling memory responder plus a bench-side copy
// engine whose expected addresses, flags and write-backs come from pixel/pair arithmetic.
module tb_cv_copy_scheduler;
  logic        clk = 1'b0, nRst;
  logic        i_start, i_read, i_writeFIFOOut, i_exitSig, i_memAck;
  logic [9:0]  i_srcX, i_dstX, i_height;
  logic [8:0]  i_srcY, i_dstY;
  logic [10:0] i_width;
  logic [2:0]  i_nextX, i_nextY;
  logic [31:0] i_wrData, i_memRData;
  logic [1:0]  i_wrMask;
  logic        o_active, o_isWidthNot1, o_xb_0, o_wb_0, o_canPush, o_canNearPush, o_endVertical;
  logic        o_currPairIsLineLast, o_nextPairIsLineLast, o_readACK, o_memReq, o_memWrite;
  logic        o_done, o_overflow;
  logic [31:0] o_readData, o_memWData;
  logic [17:0] o_memAddr;
  logic [1:0]  o_memMask, o_dbg_state;
  logic [8:0]  o_dbg_dst_last;

  int total = 0, bad = 0;
  bit mem_en = 1'b0;
  int wait_cnt = 0;
  logic [51:0] exp_q[$];
  logic [51:0] got_q[$];
  bit kind_q[$];

  cv_copy_scheduler dut (
    .clk(clk), .nRst(nRst), .i_start(i_start), .i_srcX(i_srcX), .i_dstX(i_dstX),
    .i_srcY(i_srcY), .i_dstY(i_dstY), .i_width(i_width), .i_height(i_height),
    .o_active(o_active), .o_isWidthNot1(o_isWidthNot1), .o_xb_0(o_xb_0), .o_wb_0(o_wb_0),
    .o_canPush(o_canPush), .o_canNearPush(o_canNearPush), .o_endVertical(o_endVertical),
    .o_currPairIsLineLast(o_currPairIsLineLast), .o_nextPairIsLineLast(o_nextPairIsLineLast),
    .i_read(i_read), .o_readACK(o_readACK), .o_readData(o_readData), .i_nextX(i_nextX),
    .i_nextY(i_nextY), .i_writeFIFOOut(i_writeFIFOOut), .i_wrData(i_wrData), .i_wrMask(i_wrMask),
    .i_exitSig(i_exitSig), .o_memReq(o_memReq), .o_memWrite(o_memWrite), .o_memAddr(o_memAddr),
    .o_memWData(o_memWData), .o_memMask(o_memMask), .i_memAck(i_memAck), .i_memRData(i_memRData),
    .o_done(o_done), .o_overflow(o_overflow), .o_dbg_state(o_dbg_state),
    .o_dbg_dst_last(o_dbg_dst_last)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached, bad=%0d", bad);
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] mem_word(input logic [17:0] a);
    return {a[13:0], a} ^ 32'h5A3C_0000;
  endfunction

  // memory responder: acks each request after 0..2 extra cycles, logs grant order and writes
  initial begin
    i_memAck = 1'b0; i_memRData = '0;
    forever begin
      @(posedge clk); #1;
      i_memAck = 1'b0;
      if (mem_en && nRst && o_memReq) begin
        if (wait_cnt == 0) begin
          i_memAck   = 1'b1;
          i_memRData = mem_word(o_memAddr);
          kind_q.push_back(o_memWrite);
          if (o_memWrite) got_q.push_back({o_memAddr, o_memWData, o_memMask});
          wait_cnt = $urandom_range(0, 2);
        end else begin
          wait_cnt--;
        end
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic clear_inputs();
    i_start = 0; i_read = 0; i_writeFIFOOut = 0; i_exitSig = 0;
    i_nextX = 0; i_nextY = 0; i_wrData = 0; i_wrMask = 0;
  endtask

  task automatic start_op(input int sx, input int dx, input int sy, input int dy,
                          input int w, input int h);
    i_srcX = 10'(sx); i_dstX = 10'(dx); i_srcY = 9'(sy); i_dstY = 9'(dy);
    i_width = 11'(w); i_height = 10'(h);
    i_start = 1; tick(); i_start = 0;
  endtask

  task automatic push_entry(input logic [31:0] d, input logic [1:0] m, input logic [2:0] nx,
                            input logic [2:0] ny);
    i_writeFIFOOut = 1; i_wrData = d; i_wrMask = m; i_nextX = nx; i_nextY = ny;
    tick();
    i_writeFIFOOut = 0; i_nextX = 0; i_nextY = 0;
  endtask

  task automatic finish_op(input string name);
    int k;
    i_exitSig = 1; tick(); i_exitSig = 0;
    total++;
    if (o_active !== 1'b0) begin
      bad++; $display("FAIL %s active_after_exit: got %b want 0", name, o_active);
    end
    for (k = 0; k < 400 && o_done !== 1'b1; k++) tick();
    total++;
    if (o_done !== 1'b1) begin
      bad++; $display("FAIL %s done_timeout: got %b want 1", name, o_done);
    end
    tick();
  endtask

  task automatic compare_writes(input string name);
    total++;
    if (got_q.size() != exp_q.size()) begin
      bad++; $display("FAIL %s write_count: got %0d want %0d", name, got_q.size(), exp_q.size());
    end else begin
      foreach (exp_q[j]) begin
        total++;
        if (got_q[j] !== exp_q[j]) begin
          bad++; $display("FAIL %s write[%0d]: got %h want %h", name, j, got_q[j], exp_q[j]);
        end
      end
    end
  endtask

  task automatic test_reset();
    clear_inputs(); mem_en = 0;
    nRst = 0; tick(); tick();
    total++;
    if ({o_active, o_isWidthNot1, o_xb_0, o_wb_0, o_canPush, o_canNearPush, o_endVertical,
         o_currPairIsLineLast, o_nextPairIsLineLast, o_readACK, o_readData, o_memReq, o_memWrite,
         o_memAddr, o_memWData, o_memMask, o_done, o_overflow, o_dbg_state} !== '0) begin
      bad++; $display("FAIL reset_outputs: some output nonzero (active=%b canPush=%b memReq=%b state=%0d)",
                      o_active, o_canPush, o_memReq, o_dbg_state);
    end
    nRst = 1; tick();
    total++;
    if (o_active !== 1'b0 || o_dbg_state !== 2'd0) begin
      bad++; $display("FAIL reset_idle: active=%b state=%0d want 0/0", o_active, o_dbg_state);
    end
  endtask

  // bench-side copy engine: one read then one push per source pair of each line
  task automatic run_copy(input string name, input int sx, input int dx, input int sy,
                          input int dy, input int w, input int h);
    int npairs, k, sp, syy;
    logic [31:0] d;
    logic [1:0]  m;
    logic [17:0] raddr;
    bit last;
    npairs = ((sx + w - 1) >> 1) - (sx >> 1) + 1;
    exp_q.delete(); got_q.delete(); mem_en = 1;
    start_op(sx, dx, sy, dy, w, h);
    total++;
    if (o_active !== 1'b1 || o_xb_0 !== 1'(sx % 2) || o_wb_0 !== 1'(w % 2) ||
        o_isWidthNot1 !== (w != 1)) begin
      bad++; $display("FAIL %s setup: active=%b xb0=%b wb0=%b wn1=%b want 1/%0d/%0d/%0d",
                      name, o_active, o_xb_0, o_wb_0, o_isWidthNot1, sx % 2, w % 2, w != 1);
    end
    for (int line = 0; line < h; line++) begin
      for (int i = 0; i < npairs; i++) begin
        sp = ((sx >> 1) + i) % 512;
        syy = (sy + line) % 512;
        last = (i == npairs - 1);
        total++;
        if (o_currPairIsLineLast !== last || o_nextPairIsLineLast !== (i == npairs - 2) ||
            o_endVertical !== (line == h - 1)) begin
          bad++; $display("FAIL %s flags l%0d p%0d: curr=%b next=%b endV=%b want %b/%b/%b",
                          name, line, i, o_currPairIsLineLast, o_nextPairIsLineLast,
                          o_endVertical, last, i == npairs - 2, line == h - 1);
        end
        i_read = 1; tick(); i_read = 0;
        for (k = 0; k < 60 && o_readACK !== 1'b1; k++) tick();
        raddr = {9'(syy), 9'(sp)};
        total++;
        if (o_readACK !== 1'b1) begin
          bad++; $display("FAIL %s read_timeout l%0d p%0d", name, line, i);
          return;
        end else if (o_readData !== mem_word(raddr)) begin
          bad++; $display("FAIL %s read_data l%0d p%0d: got %h want %h", name, line, i,
                          o_readData, mem_word(raddr));
        end
        for (k = 0; k < 60 && o_canPush !== 1'b1; k++) tick();
        d = $urandom; m = 2'($urandom_range(0, 3));
        push_entry(d, m, last ? 3'd6 : 3'd1, last ? 3'd4 : 3'd0);
        exp_q.push_back({9'((dy + line) % 512), 9'(((dx >> 1) + i) % 512), d, m});
      end
    end
    finish_op(name);
    compare_writes(name);
    total++;
    if (o_overflow !== 1'b0) begin
      bad++; $display("FAIL %s overflow: got %b want 0", name, o_overflow);
    end
  endtask

  task automatic test_directed();
    run_copy("aligned", 0, 40, 3, 9, 4, 2);
    run_copy("odd_start", 1, 10, 0, 0, 3, 1);
    run_copy("wrap", 1022, 1020, 511, 510, 4, 2);
    run_copy("width1", 7, 8, 100, 200, 1, 2);
  endtask

  task automatic test_random();
    for (int n = 0; n < 6; n++)
      run_copy("random", $urandom_range(0, 1023), $urandom_range(0, 1023), $urandom_range(0, 511),
               $urandom_range(0, 511), $urandom_range(1, 24), $urandom_range(1, 3));
  endtask

  task automatic test_starve();
    int k;
    bit want;
    exp_q.delete(); got_q.delete(); kind_q.delete();
    mem_en = 0;
    start_op(0, 64, 5, 6, 16, 1);
    i_read = 1; tick(); tick();
    total++;
    if (o_memReq !== 1'b1 || o_memWrite !== 1'b0) begin
      bad++; $display("FAIL starve_first_read: req=%b write=%b want 1/0", o_memReq, o_memWrite);
    end
    for (int j = 0; j < 2; j++) begin
      logic [31:0] d;
      d = $urandom;
      push_entry(d, 2'd3, 3'd0, 3'd0);
      exp_q.push_back({9'd6, 9'd32, d, 2'd3});
    end
    mem_en = 1;
    for (k = 0; k < 200 && kind_q.size() < 6; k++) tick();
    i_read = 0;
    total++;
    if (kind_q.size() < 6) begin
      bad++; $display("FAIL starve_grants: got %0d grants want 6", kind_q.size());
    end else begin
      for (int j = 0; j < 6; j++) begin
        want = (j == 5);
        total++;
        if (kind_q[j] !== want) begin
          bad++; $display("FAIL starve_order[%0d]: got write=%b want %b", j, kind_q[j], want);
        end
      end
    end
    finish_op("starve");
    compare_writes("starve");
  endtask

  task automatic test_overflow();
    logic [31:0] d;
    exp_q.delete(); got_q.delete();
    mem_en = 0;
    start_op(0, 100, 0, 7, 32, 1);
    for (int k = 0; k < 9; k++) begin
      total++;
      if (o_canPush !== (k <= 6) || o_canNearPush !== (k <= 5)) begin
        bad++; $display("FAIL ovf_space occ=%0d: canPush=%b canNear=%b want %b/%b", k,
                        o_canPush, o_canNearPush, k <= 6, k <= 5);
      end
      d = $urandom;
      push_entry(d, 2'(k), 3'd1, 3'd0);
      if (k < 8) exp_q.push_back({9'd7, 9'(50 + k), d, 2'(k)});
    end
    total++;
    if (o_overflow !== 1'b1) begin
      bad++; $display("FAIL ovf_sticky: got %b want 1", o_overflow);
    end
    mem_en = 1;
    finish_op("overflow");
    compare_writes("overflow");
    total++;
    if (o_overflow !== 1'b1) begin
      bad++; $display("FAIL ovf_held: got %b want 1", o_overflow);
    end
  endtask

  task automatic test_reset_mid_write();
    int k;
    got_q.delete(); exp_q.delete();
    mem_en = 0;
    start_op(0, 0, 0, 0, 8, 1);
    push_entry(32'hDEAD_BEEF, 2'd1, 3'd1, 3'd0);
    tick();
    total++;
    if (o_memReq !== 1'b1 || o_memWrite !== 1'b1) begin
      bad++; $display("FAIL midrst_pre: req=%b write=%b want 1/1", o_memReq, o_memWrite);
    end
    nRst = 0; tick(); nRst = 1;
    total++;
    if (o_memReq !== 1'b0 || o_active !== 1'b0 || o_overflow !== 1'b0 || o_dbg_state !== 2'd0) begin
      bad++; $display("FAIL midrst_post: req=%b active=%b ovf=%b state=%0d want 0/0/0/0",
                      o_memReq, o_active, o_overflow, o_dbg_state);
    end
    tick();
    mem_en = 1;
    start_op(0, 0, 0, 0, 8, 1);
    for (k = 0; k < 4; k++) tick();
    finish_op("midrst");
    compare_writes("midrst");
  endtask

  initial begin
    clear_inputs();
    i_srcX = 0; i_dstX = 0; i_srcY = 0; i_dstY = 0; i_width = 0; i_height = 0;
    nRst = 0;
    test_reset();
    test_directed();
    test_random();
    test_starve();
    test_overflow();
    test_reset_mid_write();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
